// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of (PC, instruction) pairs with valid/ready on both sides.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards the offered entry to decode in the same cycle.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            stored_valid;
  logic            push;
  logic            pop;

  assign stored_valid = (count != '0);
  assign in_ready     = (count != CW'(DEPTH));

  always_comb begin
    out_valid = stored_valid;
    out_pc    = stored_valid ? mem_pc[rd_ptr]   : '0;
    out_inst  = stored_valid ? mem_inst[rd_ptr] : NOP;
    push      = in_valid & in_ready & ~flush;
    pop       = stored_valid & out_ready & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: forward the offer directly; it is only stored if decode does not take it now.
    if (!stored_valid && in_valid && !flush) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
      if (out_ready) push = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= in_pc;
        mem_inst[wr_ptr] <= in_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries queued on accepted pushes, compared when decode consumes them.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_ready;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];
  logic [XLEN-1:0] popped[$];

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [XLEN-1:0] pc);
    return {pc[23:0], 8'hB3} ^ 32'h5A00_0000;
  endfunction

  // One cycle: drive inputs, check all outputs against the model mid-cycle, update model, advance past the edge.
  task automatic drive_cycle(input logic v, input logic [XLEN-1:0] pc, input logic rdy,
                             input logic fl, input string tag);
    logic            exp_ov;
    logic [XLEN-1:0] exp_pc;
    logic [31:0]     exp_inst;
    logic            exp_ir;
    logic [CW-1:0]   exp_cnt;
    logic            byp;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_ir  = (sb.size() != DEPTH);
    exp_cnt = CW'(sb.size());
    byp     = 1'b0;
    if (sb.size() != 0) begin
      exp_ov = 1'b1; exp_pc = sb[0].pc; exp_inst = sb[0].inst;
    end else begin
      exp_ov = 1'b0; exp_pc = '0; exp_inst = NOP;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (v && !fl) begin
        byp = 1'b1; exp_ov = 1'b1; exp_pc = pc; exp_inst = inst_of(pc);
      end
`endif
    end
    checks++;
    if (count !== exp_cnt) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", tag, count, exp_cnt);
    end
    checks++;
    if (in_ready !== exp_ir) begin
      errors++; $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_ir);
    end
    checks++;
    if (out_valid !== exp_ov) begin
      errors++; $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_ov);
    end
    checks++;
    if (out_pc !== exp_pc) begin
      errors++; $display("FAIL %s out_pc: got %h expected %h", tag, out_pc, exp_pc);
    end
    checks++;
    if (out_inst !== exp_inst) begin
      errors++; $display("FAIL %s out_inst: got %h expected %h", tag, out_inst, exp_inst);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_ov && rdy) popped.push_back(out_pc);
      if (exp_ov && rdy && !byp) void'(sb.pop_front());
      if (v && exp_ir && !(byp && rdy)) sb.push_back('{pc: pc, inst: inst_of(pc)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_pc !== '0 || out_inst !== NOP || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d ov=%b pc=%h inst=%h ir=%b expected 0 0 0 00000013 1",
               count, out_valid, out_pc, out_inst, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_stall;
    for (int unsigned i = 0; i < DEPTH; i++) drive_cycle(1'b1, XLEN'(4 * i), 1'b0, 1'b0, "fill");
    drive_cycle(1'b1, 'h10, 1'b0, 1'b0, "stall_offer");
    drive_cycle(1'b0, '0, 1'b0, 1'b0, "stall_idle");
    checks++;
    if (count !== CW'(DEPTH) || out_pc !== '0) begin
      errors++; $display("FAIL full_hold: got cnt=%0d pc=%h expected 4 00000000", count, out_pc);
    end
  endtask

  task automatic test_drain_wrap;
    logic [XLEN-1:0] exp_seq[$];
    exp_seq = '{'h0, 'h4, 'h8, 'hC, 'h10, 'h14};
    popped.delete();
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "pop0");
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "pop1");
    drive_cycle(1'b1, 'h10, 1'b0, 1'b0, "wrap_push0");
    drive_cycle(1'b1, 'h14, 1'b0, 1'b0, "wrap_push1");
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "drained");
    checks++;
    if (popped.size() != exp_seq.size()) begin
      errors++; $display("FAIL wrap_len: got %0d expected %0d", popped.size(), exp_seq.size());
    end else begin
      for (int i = 0; i < exp_seq.size(); i++)
        if (popped[i] !== exp_seq[i]) begin
          errors++; $display("FAIL wrap_seq[%0d]: got %h expected %h", i, popped[i], exp_seq[i]);
        end
    end
  endtask

  task automatic test_simultaneous;
    drive_cycle(1'b1, 'h20, 1'b0, 1'b0, "sim_pre0");
    drive_cycle(1'b1, 'h24, 1'b0, 1'b0, "sim_pre1");
    for (int unsigned i = 0; i < 5; i++) drive_cycle(1'b1, XLEN'('h28 + 4 * i), 1'b1, 1'b0, "sim_pp");
    checks++;
    if (count !== CW'(2)) begin
      errors++; $display("FAIL sim_count: got %0d expected 2", count);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "sim_drain0");
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "sim_drain1");
  endtask

  task automatic test_flush;
    popped.delete();
    drive_cycle(1'b1, 'h50, 1'b0, 1'b0, "fl_pre0");
    drive_cycle(1'b1, 'h54, 1'b0, 1'b0, "fl_pre1");
    drive_cycle(1'b1, 'h58, 1'b0, 1'b0, "fl_pre2");
    drive_cycle(1'b1, 'h40, 1'b1, 1'b1, "flush");
    drive_cycle(1'b1, 'h80, 1'b0, 1'b0, "post_flush_push");
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "post_flush_pop");
    drive_cycle(1'b0, '0, 1'b0, 1'b0, "post_flush_idle");
    checks++;
    if (popped.size() != 1 || popped[0] !== 'h80) begin
      errors++; $display("FAIL flush_output: got %0d entries first=%h expected 1 entry 00000080",
                         popped.size(), popped.size() ? popped[0] : '0);
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 'h60, 1'b0, 1'b0, "rm_pre0");
    drive_cycle(1'b1, 'h64, 1'b0, 1'b0, "rm_pre1");
    drive_cycle(1'b1, 'h68, 1'b0, 1'b0, "rm_pre2");
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_inst !== NOP || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d ov=%b inst=%h ir=%b expected 0 0 00000013 1",
               count, out_valid, out_inst, in_ready);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 'h0, 1'b0, 1'b0, "rm_push");
    checks++;
    if (dut.mem_pc[0] !== '0 || dut.mem_inst[0] !== inst_of('h0)) begin
      errors++; $display("FAIL rm_index0: got inst %h expected %h", dut.mem_inst[0], inst_of('h0));
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "rm_pop");
  endtask

  task automatic test_bypass;
    popped.delete();
    drive_cycle(1'b1, 'h100, 1'b1, 1'b0, "byp_offer");
    drive_cycle(1'b0, '0, 1'b1, 1'b0, "byp_after");
    drive_cycle(1'b0, '0, 1'b0, 1'b0, "byp_idle");
    checks++;
    if (popped.size() != 1 || popped[0] !== 'h100 || count !== '0) begin
      errors++; $display("FAIL bypass_result: got %0d entries cnt=%0d expected 1 entry 00000100 cnt 0",
                         popped.size(), count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_drain_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
